// File: rtl/markov_pkg.sv
// ---------------------------------------------------------------------------
// markov_pkg
// Shared definitions for the Markov learners, the table merge engine and the
// generator.
//   - entry geometry: an entry is {key, count}, count in the LSBs, where the
//     key is ORDER context symbols followed by the next symbol
//   - merge_state_t : state encoding of the table merge engine
//   - extract_key / extract_count : field helpers working on a zero-extended
//     entry bus, so one helper serves every parameterisation (ENTRY_W must
//     not exceed MAX_ENTRY_W)
// ---------------------------------------------------------------------------
package markov_pkg;

   localparam int MAX_ENTRY_W = 256;

   typedef logic [MAX_ENTRY_W-1:0] entry_bus_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COPY    = 3'd1,
      ST_FETCH_B = 3'd2,
      ST_SCAN    = 3'd3,
      ST_UPDATE  = 3'd4,
      ST_APPEND  = 3'd5,
      ST_FINISH  = 3'd6
   } merge_state_t;

   function automatic int key_width(input int order, input int sym_w);
      return (order + 1) * sym_w;
   endfunction

   function automatic int entry_width(input int order, input int sym_w, input int cnt_w);
      return key_width(order, sym_w) + cnt_w;
   endfunction

   function automatic int count_lsb();
      return 0;
   endfunction

   function automatic int key_lsb(input int cnt_w);
      return cnt_w;
   endfunction

   // Count field, right-aligned, upper bits zero.
   function automatic entry_bus_t extract_count(input entry_bus_t e, input int cnt_w);
      entry_bus_t mask;
      mask = (entry_bus_t'(1) << cnt_w) - entry_bus_t'(1);
      return (e >> count_lsb()) & mask;
   endfunction

   // Key field (context + next symbol), right-aligned, upper bits zero.
   function automatic entry_bus_t extract_key(input entry_bus_t e, input int order,
                                              input int sym_w, input int cnt_w);
      entry_bus_t mask;
      mask = (entry_bus_t'(1) << key_width(order, sym_w)) - entry_bus_t'(1);
      return (e >> key_lsb(cnt_w)) & mask;
   endfunction

endpackage

// File: rtl/markov_sat_add.sv
// ---------------------------------------------------------------------------
// markov_sat_add
// Unsigned saturating adder for occurrence counts.
//   a_i, b_i : W-bit unsigned operands
//   sum_o    : a_i + b_i clipped to 2^W-1
//   ovf_o    : 1 when the true sum did not fit in W bits
// ---------------------------------------------------------------------------
module markov_sat_add #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   logic [W:0] sum_full;

   // One extra bit holds the carry so overflow is exact.
   assign sum_full = {1'b0, a_i} + {1'b0, b_i};
   assign ovf_o    = sum_full[W];
   assign sum_o    = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];

endmodule

// File: rtl/markov_table_merge.sv
// ---------------------------------------------------------------------------
// markov_table_merge
// Copies table A into the output table, then folds each entry of table B in:
// a matching key gets its count added with saturation, a new key is appended.
// Ports:
//   clk, reset (async, active-low)
//   start          : merge request, ignored while busy
//   a_len, b_len   : valid entries in A / B, clamped to DEPTH
//   a_addr/a_rdata, b_addr/b_rdata : source reads, data one cycle later
//   o_addr/o_rdata/o_wdata/o_we    : output table, shared read/write address
//   o_len          : valid output entries
//   busy, done     : engine active / one-cycle completion pulse
//   full_err, sat_err : sticky, cleared by the next accepted start
// DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module markov_table_merge
   import markov_pkg::*;
#(
   parameter int ORDER   = 2,
   parameter int SYM_W   = 8,
   parameter int CNT_W   = 16,
   parameter int DEPTH   = 64,
   parameter int KEY_W   = key_width(ORDER, SYM_W),
   parameter int ENTRY_W = entry_width(ORDER, SYM_W, CNT_W),
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W:0]    a_len,
   input  logic [ADDR_W:0]    b_len,
   output logic [ADDR_W-1:0]  a_addr,
   output logic [ADDR_W-1:0]  b_addr,
   input  logic [ENTRY_W-1:0] a_rdata,
   input  logic [ENTRY_W-1:0] b_rdata,
   output logic [ADDR_W-1:0]  o_addr,
   input  logic [ENTRY_W-1:0] o_rdata,
   output logic [ENTRY_W-1:0] o_wdata,
   output logic               o_we,
   output logic [ADDR_W:0]    o_len,
   output logic               busy,
   output logic               done,
   output logic               full_err,
   output logic               sat_err
);

   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
      return (len > DEPTH_L) ? DEPTH_L : len;
   endfunction

   merge_state_t       state_q, state_d;
   logic [ADDR_W:0]    a_len_q, a_len_d;
   logic [ADDR_W:0]    b_len_q, b_len_d;
   logic [ADDR_W:0]    idx_q, idx_d;     // i in COPY, k in SCAN/UPDATE
   logic [ADDR_W:0]    j_q, j_d;
   logic [ADDR_W:0]    o_len_q, o_len_d;
   logic [ENTRY_W-1:0] b_entry_q, b_entry_d;
   logic               b_fresh_q, b_fresh_d;
   logic [CNT_W-1:0]   o_cnt_q, o_cnt_d;
   logic               full_err_q, full_err_d;
   logic               sat_err_q, sat_err_d;

   logic [ENTRY_W-1:0] b_cur;
   logic [KEY_W-1:0]   b_key, o_key;
   logic [CNT_W-1:0]   b_cnt, o_rd_cnt, sum_cnt;
   logic               sum_ovf;
   logic               key_hit;
   logic               table_full;

   // The B entry arrives the cycle after FETCH_B; afterwards the latched copy
   // is used so the B memory output need not stay stable.
   assign b_cur      = b_fresh_q ? b_rdata : b_entry_q;
   assign b_key      = KEY_W'(extract_key(entry_bus_t'(b_cur), ORDER, SYM_W, CNT_W));
   assign b_cnt      = CNT_W'(extract_count(entry_bus_t'(b_cur), CNT_W));
   assign o_key      = KEY_W'(extract_key(entry_bus_t'(o_rdata), ORDER, SYM_W, CNT_W));
   assign o_rd_cnt   = CNT_W'(extract_count(entry_bus_t'(o_rdata), CNT_W));
   assign key_hit    = (o_key == b_key);
   assign table_full = (o_len_q >= DEPTH_L);

   // Matched output count is latched in SCAN because o_rdata has already
   // moved on to index k+1 by the UPDATE cycle.
   markov_sat_add #(.W(CNT_W)) u_sat_add (
      .a_i   (o_cnt_q),
      .b_i   (b_cnt),
      .sum_o (sum_cnt),
      .ovf_o (sum_ovf)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         a_len_q    <= '0;
         b_len_q    <= '0;
         idx_q      <= '0;
         j_q        <= '0;
         o_len_q    <= '0;
         b_entry_q  <= '0;
         b_fresh_q  <= 1'b0;
         o_cnt_q    <= '0;
         full_err_q <= 1'b0;
         sat_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_len_q    <= a_len_d;
         b_len_q    <= b_len_d;
         idx_q      <= idx_d;
         j_q        <= j_d;
         o_len_q    <= o_len_d;
         b_entry_q  <= b_entry_d;
         b_fresh_q  <= b_fresh_d;
         o_cnt_q    <= o_cnt_d;
         full_err_q <= full_err_d;
         sat_err_q  <= sat_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      a_len_d    = a_len_q;
      b_len_d    = b_len_q;
      idx_d      = idx_q;
      j_d        = j_q;
      o_len_d    = o_len_q;
      b_entry_d  = b_cur;
      b_fresh_d  = 1'b0;
      o_cnt_d    = o_cnt_q;
      full_err_d = full_err_q;
      sat_err_d  = sat_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_len_d    = clamp_len(a_len);
               b_len_d    = clamp_len(b_len);
               o_len_d    = '0;
               full_err_d = 1'b0;
               sat_err_d  = 1'b0;
               idx_d      = '0;
               j_d        = '0;
               state_d    = ST_COPY;
            end
         end
         ST_COPY: begin
            // Cycle 0 only issues the first read; cycles 1..a_len write.
            if (idx_q != '0) begin
               o_len_d = o_len_q + ONE;
            end
            if (idx_q == a_len_q) begin
               j_d     = '0;
               state_d = (b_len_q == '0) ? ST_FINISH : ST_FETCH_B;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         ST_FETCH_B: begin
            b_fresh_d = 1'b1;
            idx_d     = '0;
            state_d   = (o_len_q == '0) ? ST_APPEND : ST_SCAN;
         end
         ST_SCAN: begin
            o_cnt_d = o_rd_cnt;
            if (key_hit) begin
               state_d = ST_UPDATE;
            end else if ((idx_q + ONE) == o_len_q) begin
               state_d = ST_APPEND;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         ST_UPDATE, ST_APPEND: begin
            if (state_q == ST_UPDATE) begin
               sat_err_d = sat_err_q | sum_ovf;
            end else if (table_full) begin
               full_err_d = 1'b1;
            end else begin
               o_len_d = o_len_q + ONE;
            end
            j_d     = j_q + ONE;
            state_d = ((j_q + ONE) < b_len_q) ? ST_FETCH_B : ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      a_addr   = '0;
      b_addr   = '0;
      o_addr   = '0;
      o_wdata  = '0;
      o_we     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      o_len    = o_len_q;
      full_err = full_err_q;
      sat_err  = sat_err_q;

      unique case (state_q)
         ST_IDLE: begin
         end
         ST_COPY: begin
            busy   = 1'b1;
            a_addr = ADDR_W'(idx_q);
            if (idx_q != '0) begin
               o_we    = 1'b1;
               o_addr  = ADDR_W'(idx_q - ONE);
               o_wdata = a_rdata;
            end
         end
         ST_FETCH_B: begin
            busy   = 1'b1;
            b_addr = ADDR_W'(j_q);
         end
         ST_SCAN: begin
            busy   = 1'b1;
            b_addr = ADDR_W'(j_q);
            // Look-ahead read; wraps harmlessly past the last entry.
            o_addr = ADDR_W'(idx_q + ONE);
         end
         ST_UPDATE: begin
            busy    = 1'b1;
            b_addr  = ADDR_W'(j_q);
            o_we    = 1'b1;
            o_addr  = ADDR_W'(idx_q);
            o_wdata = {b_key, sum_cnt};
         end
         ST_APPEND: begin
            busy   = 1'b1;
            b_addr = ADDR_W'(j_q);
            if (!table_full) begin
               o_we    = 1'b1;
               o_addr  = ADDR_W'(o_len_q);
               o_wdata = b_cur;
            end
         end
         ST_FINISH: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_markov_table_merge.sv
module tb_markov_table_merge;

   localparam int ORDER   = 2;
   localparam int SYM_W   = 8;
   localparam int CNT_W   = 8;
   localparam int DEPTH   = 8;
   localparam int ENTRY_W = 32;
   localparam int ADDR_W  = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [ADDR_W:0]    a_len = '0;
   logic [ADDR_W:0]    b_len = '0;
   logic [ADDR_W-1:0]  a_addr, b_addr, o_addr;
   logic [ENTRY_W-1:0] a_rdata = '0, b_rdata = '0, o_rdata = '0;
   logic [ENTRY_W-1:0] o_wdata;
   logic               o_we;
   logic [ADDR_W:0]    o_len;
   logic               busy, done, full_err, sat_err;

   always #5 clk = ~clk;

   markov_table_merge #(
      .ORDER (ORDER),
      .SYM_W (SYM_W),
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a_len    (a_len),
      .b_len    (b_len),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .a_rdata  (a_rdata),
      .b_rdata  (b_rdata),
      .o_addr   (o_addr),
      .o_rdata  (o_rdata),
      .o_wdata  (o_wdata),
      .o_we     (o_we),
      .o_len    (o_len),
      .busy     (busy),
      .done     (done),
      .full_err (full_err),
      .sat_err  (sat_err)
   );

   logic [ENTRY_W-1:0] A_mem [DEPTH];
   logic [ENTRY_W-1:0] B_mem [DEPTH];
   logic [ENTRY_W-1:0] O_mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int we_cnt = 0;
   int we_in_reset = 0;

   // Memories with one-cycle registered read, plus event counters.
   always @(posedge clk) begin
      a_rdata <= A_mem[a_addr];
      b_rdata <= B_mem[b_addr];
      o_rdata <= O_mem[o_addr];
      if (o_we) O_mem[o_addr] <= o_wdata;
      if (done) done_cnt <= done_cnt + 1;
      if (o_we) we_cnt <= we_cnt + 1;
      if (!reset && o_we) we_in_reset <= we_in_reset + 1;
   end

   function automatic logic [ENTRY_W-1:0] mk(input int s0, input int s1, input int s2, input int c);
      return {s0[7:0], s1[7:0], s2[7:0], c[7:0]};
   endfunction

   // ---------------- reference model ----------------
   logic [ENTRY_W-1:0] exp_o [DEPTH];
   int exp_len, exp_lat, exp_we;
   bit exp_full, exp_sat;

   task automatic model_merge(input int al, input int bl);
      int a_n, b_n, hit, sum;
      a_n = (al > DEPTH) ? DEPTH : al;
      b_n = (bl > DEPTH) ? DEPTH : bl;
      exp_len = 0; exp_we = 0; exp_full = 0; exp_sat = 0;
      for (int i = 0; i < a_n; i++) begin
         exp_o[i] = A_mem[i];
         exp_len++;
         exp_we++;
      end
      exp_lat = a_n + 1;
      for (int j = 0; j < b_n; j++) begin
         hit = -1;
         for (int k = 0; k < exp_len; k++) begin
            if (exp_o[k][31:8] == B_mem[j][31:8]) begin
               hit = k;
               break;
            end
         end
         if (hit >= 0) begin
            sum = int'(exp_o[hit][7:0]) + int'(B_mem[j][7:0]);
            if (sum > 255) begin
               sum = 255;
               exp_sat = 1;
            end
            exp_o[hit][7:0] = sum[7:0];
            exp_we++;
            exp_lat += hit + 3;
         end else begin
            exp_lat += exp_len + 2;
            if (exp_len < DEPTH) begin
               exp_o[exp_len] = B_mem[j];
               exp_len++;
               exp_we++;
            end else begin
               exp_full = 1;
            end
         end
      end
      exp_lat += 1;
   endtask

   // Pulse start, wait (bounded) for done, report latency in cycles where the
   // start cycle is cycle 0. Leaves one extra edge for counters to settle.
   task automatic run_merge(input int al, input int bl, output int lat, output bit timed_out);
      @(negedge clk);
      a_len = al[ADDR_W:0];
      b_len = bl[ADDR_W:0];
      start = 1'b1;
      lat = 0;
      timed_out = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
         if (done) begin
            lat = c;
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, o_we, full_err, sat_err, o_len, a_addr, b_addr, o_addr, o_wdata} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b we=%0b len=%0d wdata=%h, want all 0",
                  busy, done, o_we, o_len, o_wdata);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, o_we, o_len} !== '0) begin
         n_errors++;
         $display("FAIL reset_release: got busy=%0b done=%0b we=%0b len=%0d, want 0", busy, done, o_we, o_len);
      end
      $display("test_reset: done");
   endtask

   task automatic test_hit();
      int lat, d0; bit to;
      A_mem[0] = mk(1, 2, 3, 5);
      B_mem[0] = mk(1, 2, 3, 7);
      d0 = done_cnt;
      run_merge(1, 1, lat, to);
      n_checks++;
      if (to) begin n_errors++; $display("FAIL hit_timeout: no done within bound"); end
      n_checks++;
      if (O_mem[0] !== mk(1, 2, 3, 12)) begin n_errors++; $display("FAIL hit_entry: got %h want %h", O_mem[0], mk(1, 2, 3, 12)); end
      n_checks++;
      if (o_len !== 4'd1) begin n_errors++; $display("FAIL hit_len: got %0d want 1", o_len); end
      n_checks++;
      if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL hit_done_pulses: got %0d want 1", done_cnt - d0); end
      n_checks++;
      if ({full_err, sat_err} !== 2'b00) begin n_errors++; $display("FAIL hit_errs: got full=%0b sat=%0b want 0 0", full_err, sat_err); end
      n_checks++;
      if (lat != 6) begin n_errors++; $display("FAIL hit_latency: got %0d want 6", lat); end
      $display("test_hit: O[0]=%h len=%0d lat=%0d", O_mem[0], o_len, lat);
   endtask

   task automatic test_miss();
      int lat; bit to;
      A_mem[0] = mk(1, 2, 3, 5);
      B_mem[0] = mk(4, 5, 6, 1);
      run_merge(1, 1, lat, to);
      n_checks++;
      if (to) begin n_errors++; $display("FAIL miss_timeout: no done within bound"); end
      n_checks++;
      if (O_mem[1] !== mk(4, 5, 6, 1)) begin n_errors++; $display("FAIL miss_append: got %h want %h", O_mem[1], mk(4, 5, 6, 1)); end
      n_checks++;
      if (O_mem[0] !== mk(1, 2, 3, 5)) begin n_errors++; $display("FAIL miss_keep: got %h want %h", O_mem[0], mk(1, 2, 3, 5)); end
      n_checks++;
      if (o_len !== 4'd2) begin n_errors++; $display("FAIL miss_len: got %0d want 2", o_len); end
      n_checks++;
      if (lat != 6) begin n_errors++; $display("FAIL miss_latency: got %0d want 6", lat); end
      $display("test_miss: O[1]=%h len=%0d lat=%0d", O_mem[1], o_len, lat);
   endtask

   task automatic test_saturation();
      int lat; bit to;
      A_mem[0] = mk(7, 7, 1, 200);
      B_mem[0] = mk(7, 7, 1, 100);
      run_merge(1, 1, lat, to);
      n_checks++;
      if (O_mem[0] !== mk(7, 7, 1, 255)) begin n_errors++; $display("FAIL sat_count: got %h want %h", O_mem[0], mk(7, 7, 1, 255)); end
      n_checks++;
      if (sat_err !== 1'b1 || to) begin n_errors++; $display("FAIL sat_flag: got sat_err=%0b timeout=%0b want 1 0", sat_err, to); end
      run_merge(0, 0, lat, to);
      n_checks++;
      if (sat_err !== 1'b0 || to) begin n_errors++; $display("FAIL sat_clear: got sat_err=%0b timeout=%0b want 0 0", sat_err, to); end
      $display("test_saturation: count=%0d", O_mem[0][7:0]);
   endtask

   task automatic test_full();
      int lat, w0; bit to;
      for (int i = 0; i < DEPTH; i++) A_mem[i] = mk(i, i + 1, i + 2, i + 1);
      B_mem[0] = mk(9, 9, 9, 4);
      w0 = we_cnt;
      run_merge(DEPTH, 1, lat, to);
      n_checks++;
      if (we_cnt - w0 != DEPTH || to) begin n_errors++; $display("FAIL full_writes: got %0d timeout=%0b want %0d 0", we_cnt - w0, to, DEPTH); end
      n_checks++;
      if (full_err !== 1'b1) begin n_errors++; $display("FAIL full_flag: got %0b want 1", full_err); end
      n_checks++;
      if (o_len !== 4'd8) begin n_errors++; $display("FAIL full_len: got %0d want 8", o_len); end
      n_checks++;
      if (lat != 20) begin n_errors++; $display("FAIL full_latency: got %0d want 20", lat); end
      $display("test_full: len=%0d full_err=%0b lat=%0d", o_len, full_err, lat);
   endtask

   task automatic test_empty_timing();
      int lat, w0; bit to;
      w0 = we_cnt;
      run_merge(0, 0, lat, to);
      n_checks++;
      if (lat != 2 || to) begin n_errors++; $display("FAIL empty_latency: got %0d timeout=%0b want 2 0", lat, to); end
      n_checks++;
      if (we_cnt - w0 != 0) begin n_errors++; $display("FAIL empty_writes: got %0d want 0", we_cnt - w0); end
      n_checks++;
      if (o_len !== 4'd0) begin n_errors++; $display("FAIL empty_len: got %0d want 0", o_len); end
      // Hit at k=3: COPY 5 + hit 6 + FINISH 1.
      for (int i = 0; i < 4; i++) A_mem[i] = mk(10 + i, 20, 30, 2);
      B_mem[0] = mk(13, 20, 30, 3);
      run_merge(4, 1, lat, to);
      n_checks++;
      if (lat != 12 || to) begin n_errors++; $display("FAIL hit_k3_latency: got %0d timeout=%0b want 12 0", lat, to); end
      n_checks++;
      if (O_mem[3] !== mk(13, 20, 30, 5)) begin n_errors++; $display("FAIL hit_k3_entry: got %h want %h", O_mem[3], mk(13, 20, 30, 5)); end
      $display("test_empty_timing: empty lat=2 checked, k3 lat=%0d", lat);
   endtask

   task automatic test_reset_mid_scan();
      int w0;
      for (int i = 0; i < 5; i++) A_mem[i] = mk(40 + i, 1, 1, 1);
      B_mem[0] = mk(44, 1, 1, 1);
      @(negedge clk);
      a_len = 4'd5; b_len = 4'd1; start = 1'b1;
      // COPY cycles 1..6, FETCH_B cycle 7, SCAN from cycle 8.
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
      end
      w0 = we_in_reset;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, o_we, full_err, sat_err, o_len, a_addr, b_addr, o_addr, o_wdata} !== '0) begin
         n_errors++;
         $display("FAIL midreset_outputs: got busy=%0b we=%0b len=%0d oaddr=%0d, want all 0", busy, o_we, o_len, o_addr);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (we_in_reset != w0 || o_we !== 1'b0) begin n_errors++; $display("FAIL midreset_write: got %0d writes want 0", we_in_reset - w0); end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, o_len} !== '0) begin n_errors++; $display("FAIL midreset_idle: got busy=%0b len=%0d want 0 0", busy, o_len); end
      $display("test_reset_mid_scan: aborted, rerunning hit");
      test_hit();
   endtask

   task automatic test_random();
      int al, bl, lat, w0, d0; bit to;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            A_mem[i] = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 60));
            B_mem[i] = mk($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 60));
         end
         al = $urandom_range(0, 10);
         bl = $urandom_range(0, 10);
         model_merge(al, bl);
         w0 = we_cnt;
         d0 = done_cnt;
         run_merge(al, bl, lat, to);
         n_checks++;
         if (to || lat != exp_lat) begin n_errors++; $display("FAIL rand_latency it=%0d: got %0d timeout=%0b want %0d", it, lat, to, exp_lat); end
         n_checks++;
         if (int'(o_len) != exp_len) begin n_errors++; $display("FAIL rand_len it=%0d: got %0d want %0d", it, o_len, exp_len); end
         n_checks++;
         if (full_err !== exp_full || sat_err !== exp_sat) begin
            n_errors++;
            $display("FAIL rand_flags it=%0d: got full=%0b sat=%0b want %0b %0b", it, full_err, sat_err, exp_full, exp_sat);
         end
         n_checks++;
         if (we_cnt - w0 != exp_we || done_cnt - d0 != 1) begin
            n_errors++;
            $display("FAIL rand_events it=%0d: got we=%0d done=%0d want %0d 1", it, we_cnt - w0, done_cnt - d0, exp_we);
         end
         for (int i = 0; i < exp_len; i++) begin
            n_checks++;
            if (O_mem[i] !== exp_o[i]) begin n_errors++; $display("FAIL rand_entry it=%0d idx=%0d: got %h want %h", it, i, O_mem[i], exp_o[i]); end
         end
         $display("test_random it=%0d: a_len=%0d b_len=%0d len=%0d lat=%0d", it, al, bl, o_len, lat);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         A_mem[i] = '0; B_mem[i] = '0; O_mem[i] = '0;
      end
      test_reset();
      test_hit();
      test_miss();
      test_saturation();
      test_full();
      test_empty_timing();
      test_reset_mid_scan();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
